fround_pipe: RTL and testbench

- Parametrised, pipelined single-precision rounding unit for the FPU.
- Generalises the fixed 2-stage floor unit in three ways:
  - run-time rounding mode: RNE, RTZ, RDN (floor), RUP (ceil);
  - configurable pipeline depth;
  - valid/ready flow control with back-pressure.
- Produces both the rounded float and the saturated int32 conversion.
- Serves the floor/ftoi/round instructions of the core's FP execution stage.

---
 rtl/fround_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fround_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fround_pipe.sv
// rtl/fround_pipe.sv - pipelined binary32 round-to-integral with saturated int32 conversion
// Optional feature macro: FROUND_INEXACT_EN (adds the inexact output)
module fround_pipe #(
  parameter int NSTAGE       = 2,
  parameter bit DENORM_FLUSH = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic [31:0] ri,
  output logic        ovf
`ifdef FROUND_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  localparam logic [1:0] M_RNE = 2'b00;
  localparam logic [1:0] M_RTZ = 2'b01;
  localparam logic [1:0] M_RDN = 2'b10;
  localparam logic [1:0] M_RUP = 2'b11;

  localparam logic [30:0] ONE_MAG = 31'h3F800000;

  // One pipeline slot. y carries the masked operand until the increment
  // step has been applied, then the final rounded value.
  typedef struct packed {
    logic        vld;
    logic [31:0] y;
    logic        inc;
`ifdef FROUND_INEXACT_EN
    logic        inx;
`endif
    logic [31:0] ri;
    logic        ovf;
  } stage_t;

  // Decode and mask: classifies the operand, clears the fraction bits below
  // the binary point and decides whether the magnitude must be bumped.
  function automatic stage_t f_decode(input logic v, input logic [31:0] a, input logic [1:0] m);
    stage_t      r;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [7:0]  sh;
    logic [23:0] mant;
    logic [23:0] tg;
    logic [23:0] tl;
    logic [22:0] mask;
    logic [22:0] smask;
    logic        nz;
    logic        guard;
    logic        sticky;
    logic        lsb;
    logic        inx;
    r      = '0;
    s      = a[31];
    e      = a[30:23];
    f      = a[22:0];
    sh     = 8'd150 - e;
    mant   = {1'b1, f};
    tg     = mant >> (sh - 8'd1);
    tl     = mant >> sh;
    mask   = ~(23'h7FFFFF << sh);
    smask  = ~(23'h7FFFFF << (sh - 8'd1));
    guard  = tg[0];
    lsb    = tl[0];
    sticky = |(f & smask);
    nz     = (e != 8'd0) || (!DENORM_FLUSH && (f != 23'd0));
    inx    = 1'b0;
    r.vld  = v;
    r.y    = a;
    if (e == 8'hFF) begin
      inx = 1'b0;
    end else if (e >= 8'd150) begin
      inx = 1'b0;
    end else if (e < 8'd127) begin
      // |x| < 1: the answer is a signed zero or a signed one
      inx = nz;
      r.y = {s, 31'd0};
      case (m)
        M_RNE:   if (e == 8'd126 && f != 23'd0) r.y = {s, ONE_MAG};
        M_RDN:   if (s && nz) r.y = {s, ONE_MAG};
        M_RUP:   if (!s && nz) r.y = {s, ONE_MAG};
        default: r.y = {s, 31'd0};
      endcase
    end else begin
      inx = (f & mask) != 23'd0;
      r.y = {s, e, f & ~mask};
      case (m)
        M_RNE:   r.inc = guard & (sticky | lsb);
        M_RTZ:   r.inc = 1'b0;
        M_RDN:   r.inc = s & inx;
        M_RUP:   r.inc = ~s & inx;
        default: r.inc = 1'b0;
      endcase
    end
`ifdef FROUND_INEXACT_EN
    r.inx = inx;
`else
    if (inx) r.inc = r.inc;
`endif
    return r;
  endfunction

  // Increment: adding one unit in the last kept place to the {exp,frac}
  // field lets a mantissa carry roll straight into the exponent.
  function automatic stage_t f_round(input stage_t a);
    stage_t      r;
    logic [30:0] unit;
    r    = a;
    unit = 31'd1 << (8'd150 - a.y[30:23]);
    if (a.inc) r.y[30:0] = a.y[30:0] + unit;
    r.inc = 1'b0;
    return r;
  endfunction

  // Integer conversion of the already-rounded value, saturating to int32.
  function automatic stage_t f_toint(input stage_t a);
    stage_t      r;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] mag;
    r   = a;
    s   = a.y[31];
    e   = a.y[30:23];
    f   = a.y[22:0];
    mag = {8'd0, 1'b1, f};
    if (e == 8'hFF) begin
      r.ovf = 1'b1;
      r.ri  = (s && f == 23'd0) ? 32'h80000000 : 32'h7FFFFFFF;
    end else if (e >= 8'd158) begin
      if (a.y == 32'hCF000000) begin
        r.ovf = 1'b0;
        r.ri  = 32'h80000000;
      end else begin
        r.ovf = 1'b1;
        r.ri  = s ? 32'h80000000 : 32'h7FFFFFFF;
      end
    end else if (e < 8'd127) begin
      r.ovf = 1'b0;
      r.ri  = 32'd0;
    end else begin
      if (e >= 8'd150) mag = mag << (e - 8'd150);
      else             mag = mag >> (8'd150 - e);
      r.ovf = 1'b0;
      r.ri  = s ? (32'd0 - mag) : mag;
    end
    return r;
  endfunction

  stage_t stg [NSTAGE];
  stage_t nxt [NSTAGE];
  logic   adv;

  assign out_valid = stg[NSTAGE-1].vld;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign y         = stg[NSTAGE-1].y;
  assign ri        = stg[NSTAGE-1].ri;
  assign ovf       = stg[NSTAGE-1].ovf;
`ifdef FROUND_INEXACT_EN
  assign inexact   = stg[NSTAGE-1].inx;
`endif

  // Next contents of every slot: decode ahead of slot 0, increment ahead of
  // slot 1, int conversion ahead of slot 2 (or fused earlier for short pipes).
  always_comb begin
    for (int i = 0; i < NSTAGE; i++) nxt[i] = '0;
    nxt[0] = f_decode(in_valid, x, mode);
    if (NSTAGE == 1) nxt[0] = f_toint(f_round(nxt[0]));
    for (int i = 1; i < NSTAGE; i++) begin
      nxt[i] = stg[i-1];
      if (i == 1) nxt[i] = f_round(nxt[i]);
      if ((i == 1 && NSTAGE == 2) || i == 2) nxt[i] = f_toint(nxt[i]);
    end
  end

  // Pipeline registers: whole pipe shifts on advance and freezes on stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NSTAGE; i++) stg[i] <= '0;
    end else if (adv) begin
      for (int i = 0; i < NSTAGE; i++) stg[i] <= nxt[i];
    end
  end

endmodule

// File: tb/tb_fround_pipe.sv
// tb/tb_fround_pipe.sv - self-checking bench for fround_pipe
module tb_fround_pipe;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = 32'd0;
  logic [1:0]  mode = 2'd0;
  logic        in_ready, out_valid, ovf;
  logic [31:0] y, ri;
  logic        in_ready1, out_valid1, ovf1;
  logic [31:0] y1, ri1;
  logic        in_ready4, out_valid4, ovf4;
  logic [31:0] y4, ri4;
`ifdef FROUND_INEXACT_EN
  logic        inexact, inexact1, inexact4;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fround_pipe #(.NSTAGE(N), .DENORM_FLUSH(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ri(ri), .ovf(ovf)
`ifdef FROUND_INEXACT_EN
    , .inexact(inexact)
`endif
  );

  fround_pipe #(.NSTAGE(1), .DENORM_FLUSH(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1),
    .x(x), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .y(y1), .ri(ri1), .ovf(ovf1)
`ifdef FROUND_INEXACT_EN
    , .inexact(inexact1)
`endif
  );

  fround_pipe #(.NSTAGE(4), .DENORM_FLUSH(1'b1)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready4),
    .x(x), .mode(mode), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .ri(ri4), .ovf(ovf4)
`ifdef FROUND_INEXACT_EN
    , .inexact(inexact4)
`endif
  );

  typedef struct {
    logic [31:0] y;
    logic [31:0] ri;
    logic        ovf;
    logic        inx;
  } res_t;

  // Reference: value = mant * 2^(e-150); split into integer quotient and
  // remainder, round the integer, then rebuild the float from it.
  function automatic res_t model(input logic [31:0] a, input logic [1:0] m);
    res_t   r;
    logic   s;
    int     e, sh, p;
    longint mant, q, rem, half, v, t;
    bit     gt, eq, inx, up;
    s = a[31];
    e = int'(a[30:23]);
    r.y = a; r.ri = 32'd0; r.ovf = 1'b0; r.inx = 1'b0;
    if (e == 255) begin
      r.ovf = 1'b1;
      r.ri  = (s && a[22:0] == 23'd0) ? 32'h80000000 : 32'h7FFFFFFF;
      return r;
    end
    mant = (e == 0) ? 64'd0 : (longint'(a[22:0]) + (longint'(1) << 23));
    if (e >= 158) begin
      if (s && a[30:0] == 31'h4F000000) r.ri = 32'h80000000;
      else begin r.ovf = 1'b1; r.ri = s ? 32'h80000000 : 32'h7FFFFFFF; end
      return r;
    end
    if (e >= 150) begin
      v = mant << (e - 150);
      r.ri = 32'(s ? -v : v);
      return r;
    end
    sh = 150 - e;
    if (sh > 24) begin
      q = 0; gt = 0; eq = 0; inx = (mant != 0);
    end else begin
      q = mant >> sh; rem = mant - (q << sh); half = longint'(1) << (sh - 1);
      gt = rem > half; eq = rem == half; inx = rem != 0;
    end
    case (m)
      2'b00:   up = gt || (eq && (q % 2) == 1);
      2'b01:   up = 1'b0;
      2'b10:   up = s && inx;
      default: up = !s && inx;
    endcase
    q = q + (up ? 1 : 0);
    r.inx = inx;
    if (q == 0) r.y = {s, 31'd0};
    else begin
      p = 0;
      for (int i = 0; i < 40; i++) if (((q >> i) & 1) == 1) p = i;
      t = (p <= 23) ? (q << (23 - p)) : (q >> (p - 23));
      r.y = {s, 8'(127 + p), t[22:0]};
    end
    r.ri = 32'(s ? -q : q);
    return r;
  endfunction

  function automatic logic [31:0] rand_x();
    int          k;
    logic [7:0]  e;
    k = $urandom_range(0, 9);
    if (k == 0)      e = 8'hFF;
    else if (k == 1) e = 8'h00;
    else if (k <= 3) e = 8'($urandom_range(150, 160));
    else             e = 8'($urandom_range(120, 149));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (y !== 32'd0) begin n_bad++; $display("FAIL reset_y got %h want 00000000", y); end
    n_vec++; if (ri !== 32'd0) begin n_bad++; $display("FAIL reset_ri got %h want 00000000", ri); end
    n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] tx [16];
    logic [1:0]  tm [16];
    logic [31:0] ty [16];
    logic [31:0] tr [16];
    logic        to [16];
    int          lat;
    res_t        ex;
    tx = '{32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h40200000,
           32'hBF000000, 32'hBF000000, 32'hBF000000, 32'hBF000000,
           32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'hFF800000,
           32'h3F000000, 32'h3F000001, 32'h3FFFFFFF};
    tm = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1,
           2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    ty = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000,
           32'h80000000, 32'hBF800000, 32'h80000000, 32'h80000000,
           32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'hFF800000,
           32'h00000000, 32'h3F800000, 32'h40000000};
    tr = '{32'd2, 32'd1, 32'd2, 32'd1, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0,
           32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
           32'd0, 32'd1, 32'd2};
    to = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = tx[i]; mode = tm[i]; out_ready = 1'b1;
      ex = model(tx[i], tm[i]);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
      n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_timeout got out_valid %b want 1", i, out_valid); end
      n_vec++; if (lat !== N) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, N); end
      n_vec++; if (y !== ty[i]) begin n_bad++; $display("FAIL dir%0d_y x=%h got %h want %h", i, tx[i], y, ty[i]); end
      n_vec++; if (ri !== tr[i]) begin n_bad++; $display("FAIL dir%0d_ri x=%h got %h want %h", i, tx[i], ri, tr[i]); end
      n_vec++; if (ovf !== to[i]) begin n_bad++; $display("FAIL dir%0d_ovf x=%h got %b want %b", i, tx[i], ovf, to[i]); end
`ifdef FROUND_INEXACT_EN
      n_vec++; if (inexact !== ex.inx) begin n_bad++; $display("FAIL dir%0d_inexact got %b want %b", i, inexact, ex.inx); end
`else
      if (ex.inx === 1'bx) $display("note: unexpected X in reference");
`endif
    end
  endtask

  task automatic test_back_to_back(input int nops);
    res_t q[$];
    int   tag[$];
    int   adv_cnt, issued, cyc;
    logic adv;
    adv_cnt = 0; issued = 0; cyc = 0;
    while ((issued < nops || q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (issued < nops) begin
        in_valid = 1'b1; x = rand_x(); mode = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      adv = out_ready | ~out_valid;
      n_vec++; if (in_ready !== adv) begin n_bad++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, adv); end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_bad++; $display("FAIL b2b_spurious cyc %0d got out_valid 1 want 0", cyc);
        end else begin
          n_vec++; if (y !== q[0].y) begin n_bad++; $display("FAIL b2b_y cyc %0d got %h want %h", cyc, y, q[0].y); end
          n_vec++; if (ri !== q[0].ri) begin n_bad++; $display("FAIL b2b_ri cyc %0d got %h want %h", cyc, ri, q[0].ri); end
          n_vec++; if (ovf !== q[0].ovf) begin n_bad++; $display("FAIL b2b_ovf cyc %0d got %b want %b", cyc, ovf, q[0].ovf); end
`ifdef FROUND_INEXACT_EN
          n_vec++; if (inexact !== q[0].inx) begin n_bad++; $display("FAIL b2b_inexact cyc %0d got %b want %b", cyc, inexact, q[0].inx); end
`endif
          n_vec++; if (adv_cnt !== tag[0] + N) begin n_bad++; $display("FAIL b2b_latency cyc %0d got %0d want %0d", cyc, adv_cnt - tag[0], N); end
          if (out_ready) begin void'(q.pop_front()); void'(tag.pop_front()); end
        end
      end
      if (in_valid && adv) begin
        q.push_back(model(x, mode)); tag.push_back(adv_cnt); issued++;
      end
      if (adv) adv_cnt++;
      cyc++;
    end
    n_vec++; if (q.size() != 0 || issued != nops) begin n_bad++; $display("FAIL b2b_drain got %0d pending want 0", q.size()); end
  endtask

  task automatic test_midreset();
    int lat;
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = rand_x(); mode = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_loaded got %b want 1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid got %b want 0", out_valid); end
    n_vec++; if (y !== 32'd0) begin n_bad++; $display("FAIL mrst_y got %h want 00000000", y); end
    n_vec++; if (ri !== 32'd0) begin n_bad++; $display("FAIL mrst_ri got %h want 00000000", ri); end
    n_vec++; if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid4 got %b want 0", out_valid4); end
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b1; x = 32'h3F800000; mode = 2'd1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    n_vec++; if (lat !== N) begin n_bad++; $display("FAIL mrst_latency got %0d want %0d", lat, N); end
    n_vec++; if (y !== 32'h3F800000) begin n_bad++; $display("FAIL mrst_y_after got %h want 3f800000", y); end
    n_vec++; if (ri !== 32'd1) begin n_bad++; $display("FAIL mrst_ri_after got %h want 00000001", ri); end
  endtask

  task automatic test_sweep();
    int lat1, lat2, lat4;
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++; if ({in_ready1, in_ready, in_ready4} !== 3'b111) begin n_bad++; $display("FAIL sweep_ready got %b want 111", {in_ready1, in_ready, in_ready4}); end
    in_valid = 1'b1; x = 32'h3FC00000; mode = 2'd0;
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid1 && lat1 == 0) begin
        lat1 = c;
        n_vec++; if ({y1, ri1, ovf1} !== {32'h40000000, 32'd2, 1'b0}) begin n_bad++; $display("FAIL sweep1_result got %h/%h/%b want 40000000/00000002/0", y1, ri1, ovf1); end
      end
      if (out_valid && lat2 == 0) begin
        lat2 = c;
        n_vec++; if ({y, ri, ovf} !== {32'h40000000, 32'd2, 1'b0}) begin n_bad++; $display("FAIL sweep2_result got %h/%h/%b want 40000000/00000002/0", y, ri, ovf); end
      end
      if (out_valid4 && lat4 == 0) begin
        lat4 = c;
        n_vec++; if ({y4, ri4, ovf4} !== {32'h40000000, 32'd2, 1'b0}) begin n_bad++; $display("FAIL sweep4_result got %h/%h/%b want 40000000/00000002/0", y4, ri4, ovf4); end
      end
    end
    n_vec++; if (lat1 !== 1) begin n_bad++; $display("FAIL sweep1_latency got %0d want 1", lat1); end
    n_vec++; if (lat2 !== 2) begin n_bad++; $display("FAIL sweep2_latency got %0d want 2", lat2); end
    n_vec++; if (lat4 !== 4) begin n_bad++; $display("FAIL sweep4_latency got %0d want 4", lat4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(10);
    test_back_to_back(60);
    test_midreset();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
